stream_pattern_gen: RTL

STREAM_PATTERN_GEN -- requirements
Module: stream_pattern_gen

---
 rtl/stream_pattern_gen.sv | 122 ++++++++++++
 1 files changed

// File: rtl/stream_pattern_gen.sv
// AXI-Stream burst pattern source: emits packets of incrementing sequence numbers
// with optional idle gaps between packets, plus lifetime beat/packet counters.
module stream_pattern_gen #(
  parameter int C_AXIS_BYTEWIDTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic [15:0]                     pkt_beats,
  input  logic [15:0]                     num_pkts,
  input  logic [7:0]                      gap_cycles,
  output logic                            output_m_axis_tvalid,
  output logic [C_AXIS_BYTEWIDTH*8-1:0]   output_m_axis_tdata,
  output logic [C_AXIS_BYTEWIDTH-1:0]     output_m_axis_tstrb,
  output logic                            output_m_axis_tlast,
  input  logic                            output_m_axis_tready,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     beats_sent,
  output logic [31:0]                     pkts_sent
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]  r_state;
  logic [15:0] r_pkt_beats, r_num_pkts, r_beat_idx, r_pkt_idx;
  logic [7:0]  r_gap, r_gap_cnt;
  logic [31:0] r_seq, r_beats_sent, r_pkts_sent;
  logic        r_done;

  logic w_valid, w_last, w_xfer, w_final_pkt;

  assign w_valid     = (r_state == S_SEND);
  assign w_last      = w_valid && (r_beat_idx == r_pkt_beats - 16'd1);
  assign w_xfer      = w_valid && output_m_axis_tready;
  assign w_final_pkt = (r_pkt_idx == r_num_pkts - 16'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_pkt_beats  <= '0;
      r_num_pkts   <= '0;
      r_gap        <= '0;
      r_beat_idx   <= '0;
      r_pkt_idx    <= '0;
      r_gap_cnt    <= '0;
      r_seq        <= '0;
      r_done       <= 1'b0;
      r_beats_sent <= '0;
      r_pkts_sent  <= '0;
    end else begin
      r_done       <= 1'b0;
      // Written every cycle so the lifetime counters always advance from their current value.
      r_beats_sent <= r_beats_sent + {31'd0, w_xfer};
      r_pkts_sent  <= r_pkts_sent + {31'd0, w_xfer & w_last};
      case (r_state)
        S_IDLE: begin
          if (start) begin
            if (pkt_beats == 16'd0 || num_pkts == 16'd0) begin
              r_done <= 1'b1;
            end else begin
              r_pkt_beats <= pkt_beats;
              r_num_pkts  <= num_pkts;
              r_gap       <= gap_cycles;
              r_beat_idx  <= '0;
              r_pkt_idx   <= '0;
              r_seq       <= '0;
              r_state     <= S_SEND;
            end
          end
        end
        S_SEND: begin
          if (w_xfer) begin
            r_seq <= r_seq + 32'd1;
            if (w_last) begin
              r_beat_idx <= '0;
              if (w_final_pkt) begin
                r_state <= S_IDLE;
                r_done  <= 1'b1;
              end else begin
                r_pkt_idx <= r_pkt_idx + 16'd1;
                if (r_gap != 8'd0) begin
                  r_gap_cnt <= r_gap;
                  r_state   <= S_GAP;
                end
              end
            end else begin
              r_beat_idx <= r_beat_idx + 16'd1;
            end
          end
        end
        S_GAP: begin
          // Counter is loaded with a non-zero gap, so the final idle cycle is count==1.
          if (r_gap_cnt == 8'd1) r_state <= S_SEND;
          else                   r_gap_cnt <= r_gap_cnt - 8'd1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  generate
    if (C_AXIS_BYTEWIDTH > 4) begin : g_ext
      assign output_m_axis_tdata = {{(C_AXIS_BYTEWIDTH*8-32){1'b0}}, r_seq};
    end else if (C_AXIS_BYTEWIDTH == 4) begin : g_eq
      assign output_m_axis_tdata = r_seq;
    end else begin : g_trunc
      assign output_m_axis_tdata = r_seq[C_AXIS_BYTEWIDTH*8-1:0];
    end
  endgenerate

  assign output_m_axis_tvalid = w_valid;
  assign output_m_axis_tstrb  = {C_AXIS_BYTEWIDTH{w_valid}};
  assign output_m_axis_tlast  = w_last;
  assign busy                 = (r_state != S_IDLE);
  assign done                 = r_done;
  assign beats_sent           = r_beats_sent;
  assign pkts_sent            = r_pkts_sent;

endmodule
